mandelbrot_cfg_serializer: RTL
==============================

// Module: mandelbrot_cfg_serializer
// PURPOSE
//  Transmit end of the 33-bit serial configuration interface of the tiny mandelbrot engine.
//  - Latches a parallel configuration word and shifts it out MSB-first on a data/shift-enable pin pair.
//  - Drives the engine's config receiver: enable on ui_in[4], data on ui_in[5].
//  - Used in FPGA harnesses and the on-chip demo sequencer.
//  - Optionally pulses run after a frame completes.
// PARAMETERS
//  BIT_CYCLES  4   clock cycles per serial bit, >=1
//  CFG_WIDTH   33  frame length in bits; must equal the receiver shift register width
// PORTS
//  clk         in   1   single clock; all logic on posedge
//  rst_n       in   1   synchronous, active-low reset
//  start       in   1   request to transmit cfg_word; sampled only in IDLE
//  auto_run    in   1   sampled with start; if 1, pulse run_o after done
//  cfg_word    in   33  {max_ctr[6:0], ctr_select[1:0], scaling[1:0], ci_offset[10:0], cr_offset[10:0]}
//  sdata       out  1   serial data to receiver
//  sen         out  1   shift enable; receiver shifts sdata in on posedge clk when sen=1
//  busy        out  1   high from the cycle after start accepted until done
//  done        out  1   one-cycle pulse after the last bit's sen cycle
//  run_o       out  1   one-cycle pulse on the cycle after done, only if auto_run was latched
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; sdata=0, sen=0, busy=0, done=0, run_o=0; shadow and counters cleared.
//  Reset wins over every other input on the same edge.
//  States: IDLE -> SHIFT -> DONE -> (RUN if run latched) -> IDLE.
//  IDLE, start=1 at edge t:
//   - shadow<=cfg_word, run_lat<=auto_run, bit_idx<=CFG_WIDTH-1, phase<=0, state<=SHIFT.
//   - cfg_word changes after t have no effect on the frame.
//  SHIFT:
//   - sdata = shadow[bit_idx], stable for the whole bit period.
//   - phase counts 0..BIT_CYCLES-1; sen=1 only when phase==BIT_CYCLES-1.
//   - BIT_CYCLES=1 gives sen=1 on every SHIFT cycle.
//   - At phase wrap: bit_idx decrements. At bit_idx==0 with phase==BIT_CYCLES-1, the next state is DONE.
//   - Exactly CFG_WIDTH sen cycles per frame. First bit sent = cfg_word[32]; it lands in receiver bit 32.
//  Timing:
//   - busy=1 from t+1 through the last SHIFT cycle.
//   - First sen at t+BIT_CYCLES; last sen at t+CFG_WIDTH*BIT_CYCLES.
//  DONE (1 cycle): done=1, busy=0, sen=0, sdata=0.
//  RUN (1 cycle): run_o=1.
//  start in SHIFT/DONE/RUN is ignored, not queued; a new frame is accepted only once back in IDLE.
//   - Back-to-back minimum: next start accepted on the first IDLE cycle after DONE/RUN.
//  Outputs are registered; no combinational path from any input to any output.
//  sen is never high outside SHIFT; no partial frame resumes after reset.
//  Widths: bit_idx $clog2(CFG_WIDTH); phase $clog2(BIT_CYCLES) with a minimum of 1 bit; no wrap past 0.
// STRUCTURE
//  Package mandelbrot_cfg_pkg:
//   - CFG_WIDTH=33.
//   - Field LSB/width constants: CR_OFF 0/11, CI_OFF 11/11, SCALING 22/2, CTR_SEL 24/2, MAX_CTR 26/7.
//   - State enum {IDLE, SHIFT, DONE, RUN}.
//   - Function pack_cfg(max_ctr, ctr_sel, scaling, ci, cr) -> 33-bit word.
//  Sub-module cfg_bit_timer: phase counter with enable, emitting strobe on the terminal phase.
//  Everything else (FSM, shadow register, bit index) stays in this module.
// TESTING
//  Bench model: 33-bit shift register {r[31:0], sdata} clocked when sen=1, identical to the engine receiver.
//  1. Reset held 3 cycles mid-frame -> all outputs 0 next cycle; model receives no further sen.
//  2. BIT_CYCLES=1, cfg_word=33'h1_5A5A_A5A5, start at t -> sen high t+1..t+33, model==word, done at t+34, busy 0.
//  3. BIT_CYCLES=4, word=pack_cfg(7'd100,2'd1,2'd2,11'h3FF,11'h400) -> sen every 4th cycle, 33 pulses, model fields decode back.
//  4. start pulsed at bit 10 with a different cfg_word -> ignored; model holds the first word; one done only.
//  5. auto_run=1 -> run_o single pulse on the cycle after done. auto_run=0 -> run_o stays 0.
//  6. start held high continuously -> frames separated by DONE(+RUN) plus one IDLE cycle; each frame is exactly 33 sen.

Source files
------------

// File: rtl/mandelbrot_cfg_pkg.sv
// mandelbrot_cfg_pkg: config frame layout, FSM states and word packing for the mandelbrot config link.
package mandelbrot_cfg_pkg;
    localparam int CFG_WIDTH   = 33;
    localparam int CR_OFF_LSB  = 0;
    localparam int CR_OFF_W    = 11;
    localparam int CI_OFF_LSB  = 11;
    localparam int CI_OFF_W    = 11;
    localparam int SCALING_LSB = 22;
    localparam int SCALING_W   = 2;
    localparam int CTR_SEL_LSB = 24;
    localparam int CTR_SEL_W   = 2;
    localparam int MAX_CTR_LSB = 26;
    localparam int MAX_CTR_W   = 7;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, RUN} state_e;

    function automatic logic [CFG_WIDTH-1:0] pack_cfg(
        input logic [MAX_CTR_W-1:0] max_ctr,
        input logic [CTR_SEL_W-1:0] ctr_sel,
        input logic [SCALING_W-1:0] scaling,
        input logic [CI_OFF_W-1:0]  ci,
        input logic [CR_OFF_W-1:0]  cr
    );
        return {max_ctr, ctr_sel, scaling, ci, cr};
    endfunction
endpackage

// File: rtl/cfg_bit_timer.sv
// cfg_bit_timer: per-bit phase counter; strobe marks the terminal phase of each serial bit.
module cfg_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic strobe
);
    localparam int PW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(BIT_CYCLES - 1);

    logic [PW-1:0] phase_q, phase_d;

    // Phase is held at 0 while disabled so every frame starts on a fresh bit period.
    always_comb begin
        strobe  = en && (phase_q == LAST);
        phase_d = (en && !strobe) ? phase_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) phase_q <= '0;
        else        phase_q <= phase_d;
    end
endmodule

// File: rtl/mandelbrot_cfg_serializer.sv
// mandelbrot_cfg_serializer: latches a config word and shifts it MSB-first on sdata/sen,
// then signals done and optionally pulses run.
module mandelbrot_cfg_serializer #(
    parameter int BIT_CYCLES = 4,
    parameter int CFG_WIDTH  = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 auto_run,
    input  logic [CFG_WIDTH-1:0] cfg_word,
    output logic                 sdata,
    output logic                 sen,
    output logic                 busy,
    output logic                 done,
    output logic                 run_o
);
    import mandelbrot_cfg_pkg::*;

    localparam int IW = $clog2(CFG_WIDTH);

    state_e               state_q, state_d;
    logic [CFG_WIDTH-1:0] shadow_q, shadow_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 run_lat_q, run_lat_d;
    logic                 strobe;

    cfg_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q == SHIFT),
        .strobe (strobe)
    );

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        run_lat_d = run_lat_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = SHIFT;
                shadow_d  = cfg_word;
                run_lat_d = auto_run;
                idx_d     = IW'(CFG_WIDTH - 1);
            end
            SHIFT: if (strobe) begin
                if (idx_q == '0) state_d = DONE;
                else             idx_d   = idx_q - 1'b1;
            end
            DONE:    state_d = run_lat_q ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        busy  = state_q == SHIFT;
        sdata = busy && shadow_q[idx_q];
        sen   = strobe;
        done  = state_q == DONE;
        run_o = state_q == RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            idx_q     <= '0;
            run_lat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            run_lat_q <= run_lat_d;
        end
    end
endmodule
